fifo_wr_arbiter: RTL

- Shares the single write port of one `fifo` instance between N_REQ producers.
- Round-robin arbitration with a grant locked for one burst. A burst ends on the requester's `last` beat, or after MAX_BURST beats, whichever comes first.
- Sits directly in front of the FIFO write side, on the same clk/ce/rst, and drives `w_data`/`we` while observing `full`.

---
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared FIFO write port
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_last,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]       fifo_w_data,
   output logic                    fifo_we,
   input  logic                    fifo_full,
   output logic [N_REQ-1:0]        grant,
   output logic                    busy
);

   localparam int OW = $clog2(N_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state, state_n;
   logic [OW-1:0]     owner, owner_n;
   logic [OW-1:0]     last_owner, last_owner_n;
   logic [OW-1:0]     pick, cand;
   logic [CW-1:0]     beat_cnt, beat_cnt_n;
   logic [DATA_W-1:0] req_arr [N_REQ];
   logic              xfer;
   int                sum;

   genvar g;
   generate
      for (g = 0; g < N_REQ; g++) begin : g_unpack
         assign req_arr[g] = req_data[g*DATA_W +: DATA_W];
      end
   endgenerate

   // Scan from the farthest candidate inward so the nearest one after last_owner wins.
   always_comb begin
      pick = last_owner;
      cand = '0;
      sum  = 0;
      for (int k = N_REQ; k >= 1; k--) begin
         sum = int'(last_owner) + k;
         if (sum >= N_REQ)
            sum = sum - N_REQ;
         cand = OW'(sum);
         if (req_valid[cand])
            pick = cand;
      end
   end

   assign xfer = ce & (state == GRANT) & req_valid[owner] & ~fifo_full;

   always_ff @(posedge clk) begin
      if (ce) begin
         if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(N_REQ - 1);
            beat_cnt   <= '0;
         end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            beat_cnt   <= beat_cnt_n;
         end
      end
   end

   always_comb begin
      state_n      = state;
      owner_n      = owner;
      last_owner_n = last_owner;
      beat_cnt_n   = beat_cnt;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               owner_n    = pick;
               beat_cnt_n = '0;
               state_n    = GRANT;
            end
         end
         GRANT: begin
            if (xfer) begin
               if (req_last[owner] || beat_cnt == CW'(MAX_BURST - 1)) begin
                  last_owner_n = owner;
                  state_n      = IDLE;
               end else begin
                  beat_cnt_n = beat_cnt + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      grant       = '0;
      busy        = 1'b0;
      fifo_we     = 1'b0;
      fifo_w_data = '0;
      req_ready   = '0;
      if (state == GRANT) begin
         grant[owner]     = 1'b1;
         busy             = 1'b1;
         fifo_we          = req_valid[owner];
         fifo_w_data      = req_arr[owner];
         req_ready[owner] = xfer;
      end
   end

endmodule
